// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of an incoming square-wave tone in clk
// cycles, declares lock once successive periods agree within a tolerance,
// and flags silence after a programmable number of milliseconds without an
// accepted edge.
`timescale 1ns/1ps

module tone_decoder #(
    parameter int PW          = 16,
    parameter int MATCH_COUNT = 4,
    parameter int TOL         = 2,
    parameter int MIN_PERIOD  = 8,
    parameter int SILENCE_MS  = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   ticks_per_milli,
    input  logic          sound,
    output logic [PW-1:0] period,
    output logic          period_strobe,
    output logic          locked,
    output logic          note_start,
    output logic          silence
);

    typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_t;

    state_t state, state_nxt;

    logic          sync_p0, sync_p1, edge_p2;
    logic          rise, glitch, accept, timeout, in_tol;
    logic [PW-1:0] cnt;
    logic [PW-1:0] ref_period, ref_nxt, period_nxt;
    logic [3:0]    match_cnt, match_nxt;
    logic [15:0]   tick_cnt, tpm_eff;
    logic [7:0]    ms_cnt;
    logic [PW:0]   diff_mag;
    logic          strobe_nxt, locked_nxt, note_nxt, silence_nxt;

    // Period counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [PW-1:0] sat_inc_cnt(input logic [PW-1:0] v);
        return (v == '1) ? v : v + PW'(1);
    endfunction

    // Millisecond counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc_ms(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Magnitude of a - b, computed one bit wider so the sign never aliases.
    function automatic logic [PW:0] abs_diff(input logic [PW-1:0] a,
                                             input logic [PW-1:0] b);
        logic signed [PW:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    assign rise     = sync_p1 & ~edge_p2;
    assign glitch   = (cnt < PW'(MIN_PERIOD));
    assign accept   = rise & ((state == IDLE) | ~glitch);
    assign timeout  = (ms_cnt == 8'(SILENCE_MS)) && (state != IDLE);
    assign tpm_eff  = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
    assign diff_mag = abs_diff(cnt, ref_period);
    assign in_tol   = (diff_mag <= (PW+1)'(TOL));

    // Two-flop synchroniser on the asynchronous pin, then an edge register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            edge_p2 <= 1'b0;
        end else begin
            sync_p0 <= sound;
            sync_p1 <= sync_p0;
            edge_p2 <= sync_p1;
        end
    end

    // Period counter and the millisecond silence timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            tick_cnt <= 16'd0;
            ms_cnt   <= 8'd0;
        end else begin
            cnt <= accept ? PW'(1) : sat_inc_cnt(cnt);
            if (accept || state == IDLE) begin
                tick_cnt <= 16'd0;
                ms_cnt   <= 8'd0;
            end else if (tick_cnt >= tpm_eff - 16'd1) begin
                tick_cnt <= 16'd0;
                ms_cnt   <= sat_inc_ms(ms_cnt);
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and next-output decode; an accepted rise beats a timeout.
    always_comb begin
        state_nxt   = state;
        ref_nxt     = ref_period;
        match_nxt   = match_cnt;
        period_nxt  = period;
        strobe_nxt  = 1'b0;
        note_nxt    = 1'b0;
        locked_nxt  = locked;
        silence_nxt = silence;
        case (state)
            IDLE: begin
                silence_nxt = 1'b1;
                locked_nxt  = 1'b0;
                if (rise) begin
                    state_nxt   = ARMED;
                    silence_nxt = 1'b0;
                end
            end
            ARMED: begin
                if (accept) begin
                    state_nxt  = TRACK;
                    period_nxt = cnt;
                    strobe_nxt = 1'b1;
                    ref_nxt    = cnt;
                    match_nxt  = 4'd1;
                end
            end
            TRACK: begin
                if (accept) begin
                    period_nxt = cnt;
                    strobe_nxt = 1'b1;
                    if (in_tol) begin
                        match_nxt = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 == 4'(MATCH_COUNT)) begin
                            state_nxt  = LOCKED;
                            locked_nxt = 1'b1;
                            note_nxt   = 1'b1;
                        end
                    end else begin
                        ref_nxt   = cnt;
                        match_nxt = 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    period_nxt = cnt;
                    strobe_nxt = 1'b1;
                    if (!in_tol) begin
                        state_nxt  = TRACK;
                        locked_nxt = 1'b0;
                        ref_nxt    = cnt;
                        match_nxt  = 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (timeout && !accept) begin
            state_nxt   = IDLE;
            silence_nxt = 1'b1;
            locked_nxt  = 1'b0;
            period_nxt  = '0;
            strobe_nxt  = 1'b0;
            note_nxt    = 1'b0;
        end
    end

    // Registered outputs and tracking reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            period        <= '0;
            period_strobe <= 1'b0;
            locked        <= 1'b0;
            note_start    <= 1'b0;
            silence       <= 1'b1;
            ref_period    <= '0;
            match_cnt     <= 4'd0;
        end else begin
            period        <= period_nxt;
            period_strobe <= strobe_nxt;
            locked        <= locked_nxt;
            note_start    <= note_nxt;
            silence       <= silence_nxt;
            ref_period    <= ref_nxt;
            match_cnt     <= match_nxt;
        end
    end

endmodule
